// File: rtl/calc_pkg.sv
// +----------------------------------------------------------------------+
// | calc_pkg: shared op, sequencer and power encodings for calc_controller|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_SOMA = 2'b10;
    localparam logic [1:0] OP_SUBT = 2'b11;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_START    = 3'd1,
        SEQ_WAIT_ULA = 3'd2,
        SEQ_LCD_REQ  = 3'd3,
        SEQ_LCD_WAIT = 3'd4
    } seq_state_t;

    typedef enum logic {
        PWR_OFF = 1'b0,
        PWR_ON  = 1'b1
    } pwr_state_t;

    // Rising-edge vector is {subt, soma, mult}; lower index wins.
    function automatic logic [1:0] op_select(input logic [2:0] rise);
        logic [1:0] op;
        op = OP_NONE;
        if (rise[0]) begin
            op = OP_MULT;
        end else if (rise[1]) begin
            op = OP_SOMA;
        end else if (rise[2]) begin
            op = OP_SUBT;
        end
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_controller_btn_debounce.sv
// +----------------------------------------------------------------------+
// | btn_debounce: 2-FF synchronizer followed by a stability counter      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
    parameter int DB_CYC = 1000,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db
);

    localparam logic [CNT_W-1:0] DB_THR  = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synchronized sample disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q + CNT_ONE >= DB_THR) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = level_q;

endmodule

`default_nettype wire

// File: rtl/calc_controller.sv
// +----------------------------------------------------------------------+
// | calc_controller: button debounce, power state and ULA/LCD sequencer  |
// | Optional ULA timeout with sticky ula_err: CALC_ULA_TIMEOUT_EN        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module calc_controller
    import calc_pkg::*;
#(
    parameter int DB_CYC      = 1000,
    parameter int PWR_ON_CYC  = 50000,
    parameter int PWR_OFF_CYC = 25000,
    parameter int CNT_W       = 16
`ifdef CALC_ULA_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       botao_1,
    input  logic       botao_2,
    input  logic       botao_3,
    input  logic       botao_4,
    output logic [1:0] ula_op,
    output logic       ula_start,
    input  logic       ula_done,
    output logic       lcd_req,
    input  logic       lcd_ack,
    output logic       power_on,
    output logic       busy
`ifdef CALC_ULA_TIMEOUT_EN
    ,
    output logic       ula_err
`endif
);

    localparam logic [CNT_W-1:0] ON_THR  = CNT_W'(PWR_ON_CYC);
    localparam logic [CNT_W-1:0] OFF_THR = CNT_W'(PWR_OFF_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0] btn_raw;
    logic [3:0] btn_db;

    assign btn_raw = {botao_4, botao_3, botao_2, botao_1};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DB_CYC (DB_CYC),
            .CNT_W  (CNT_W)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[i]),
            .btn_db  (btn_db[i])
        );
    end

    pwr_state_t       pwr_q;
    pwr_state_t       pwr_d;
    logic             armed_q;
    logic             armed_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] hold_thr;
    logic             pwr_off_evt;
    logic             pwr_ok;

    logic [2:0]       op_prev_q;
    logic [2:0]       op_rise;

    seq_state_t       seq_q;
    seq_state_t       seq_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic             start_q;
    logic             start_d;
    logic             lcd_req_q;
    logic             lcd_req_d;
    logic             busy_q;
    logic             busy_d;

`ifdef CALC_ULA_TIMEOUT_EN
    localparam int             TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_THR = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_d;
    logic            err_q;
    logic            err_d;
`endif

    assign op_rise  = btn_db[2:0] & ~op_prev_q;
    assign hold_thr = (pwr_q == PWR_ON) ? OFF_THR : ON_THR;

    // Hold counter only runs while armed, so one continuous press toggles once.
    always_comb begin
        pwr_d       = pwr_q;
        armed_d     = armed_q;
        hold_d      = hold_q;
        pwr_off_evt = 1'b0;
        if (!btn_db[3]) begin
            hold_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (hold_q + CNT_ONE >= hold_thr) begin
                pwr_d       = (pwr_q == PWR_ON) ? PWR_OFF : PWR_ON;
                hold_d      = '0;
                armed_d     = 1'b0;
                pwr_off_evt = (pwr_q == PWR_ON);
            end else begin
                hold_d = hold_q + CNT_ONE;
            end
        end
    end

    // The cycle that turns power off already forces the sequencer back to IDLE.
    assign pwr_ok = (pwr_q == PWR_ON) && !pwr_off_evt;

    always_comb begin
        seq_d = seq_q;
        op_d  = op_q;
`ifdef CALC_ULA_TIMEOUT_EN
        to_d  = '0;
        err_d = err_q;
`endif
        if (!pwr_ok) begin
            seq_d = SEQ_IDLE;
            op_d  = OP_NONE;
`ifdef CALC_ULA_TIMEOUT_EN
            err_d = 1'b0;
`endif
        end else begin
            case (seq_q)
                SEQ_IDLE: begin
                    if (|op_rise) begin
                        op_d  = op_select(op_rise);
                        seq_d = SEQ_START;
`ifdef CALC_ULA_TIMEOUT_EN
                        err_d = 1'b0;
`endif
                    end
                end
                SEQ_START: begin
                    seq_d = SEQ_WAIT_ULA;
                end
                SEQ_WAIT_ULA: begin
                    if (ula_done) begin
                        seq_d = SEQ_LCD_REQ;
                    end
`ifdef CALC_ULA_TIMEOUT_EN
                    else if (to_q + TO_ONE >= TO_THR) begin
                        seq_d = SEQ_IDLE;
                        err_d = 1'b1;
                    end else begin
                        to_d = to_q + TO_ONE;
                    end
`endif
                end
                SEQ_LCD_REQ: begin
                    if (lcd_ack) begin
                        seq_d = SEQ_LCD_WAIT;
                    end
                end
                SEQ_LCD_WAIT: begin
                    if (!lcd_ack) begin
                        seq_d = SEQ_IDLE;
                    end
                end
                default: begin
                    seq_d = SEQ_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered copies of the next-state decode.
    always_comb begin
        start_d   = (seq_d == SEQ_START);
        lcd_req_d = (seq_d == SEQ_LCD_REQ);
        busy_d    = (seq_d != SEQ_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_q     <= PWR_OFF;
            armed_q   <= 1'b0;
            hold_q    <= '0;
            op_prev_q <= '0;
            seq_q     <= SEQ_IDLE;
            op_q      <= OP_NONE;
            start_q   <= 1'b0;
            lcd_req_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef CALC_ULA_TIMEOUT_EN
            to_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            pwr_q     <= pwr_d;
            armed_q   <= armed_d;
            hold_q    <= hold_d;
            op_prev_q <= btn_db[2:0];
            seq_q     <= seq_d;
            op_q      <= op_d;
            start_q   <= start_d;
            lcd_req_q <= lcd_req_d;
            busy_q    <= busy_d;
`ifdef CALC_ULA_TIMEOUT_EN
            to_q      <= to_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ula_op    = op_q;
    assign ula_start = start_q;
    assign lcd_req   = lcd_req_q;
    assign busy      = busy_q;
    assign power_on  = (pwr_q == PWR_ON);
`ifdef CALC_ULA_TIMEOUT_EN
    assign ula_err   = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_controller.sv
// +----------------------------------------------------------------------+
// | tb_calc_controller: self-checking bench for calc_controller          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_calc_controller;

    localparam int DB   = 3;
    localparam int PON  = 8;
    localparam int POFF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       botao_1, botao_2, botao_3, botao_4;
    logic [1:0] ula_op;
    logic       ula_start;
    logic       ula_done;
    logic       lcd_req;
    logic       lcd_ack;
    logic       power_on;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Responder (ULA/LCD stand-in) and start monitor state.
    int         ula_lat  = 5;
    int         ack_lat  = 2;
    int         done_cd  = 0;
    int         ack_cd   = 0;
    int         ack_hold = 0;
    bit         ack_wait = 1'b0;
    int         n_start  = 0;
    int         start_run = 0;
    int         max_run  = 0;
    logic [1:0] op_at_start = 2'b00;

    always #5 clk = ~clk;

    calc_controller #(
        .DB_CYC      (DB),
        .PWR_ON_CYC  (PON),
        .PWR_OFF_CYC (POFF),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .botao_1   (botao_1),
        .botao_2   (botao_2),
        .botao_3   (botao_3),
        .botao_4   (botao_4),
        .ula_op    (ula_op),
        .ula_start (ula_start),
        .ula_done  (ula_done),
        .lcd_req   (lcd_req),
        .lcd_ack   (lcd_ack),
        .power_on  (power_on),
        .busy      (busy)
    );

    // Expected op from the priority rule: mult beats soma beats subt.
    function automatic logic [1:0] model_op(input int mask);
        if ((mask & 1) != 0) return 2'd1;
        if ((mask & 2) != 0) return 2'd2;
        return 2'd3;
    endfunction

    // One clock: sample just after the edge, then update the responder.
    task automatic step();
        @(posedge clk);
        #1;
        if (ula_start === 1'b1) begin
            n_start++;
            start_run++;
            op_at_start = ula_op;
            if (start_run > max_run) max_run = start_run;
        end else begin
            start_run = 0;
        end
        ula_done = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) ula_done = 1'b1;
        end
        if (ula_start === 1'b1) begin
            if (ula_lat <= 1) ula_done = 1'b1;
            else done_cd = ula_lat - 1;
        end
        if (lcd_ack && !lcd_req) begin
            if (ack_hold > 0) ack_hold--;
            else lcd_ack = 1'b0;
        end else if (ack_wait) begin
            ack_cd--;
            if (ack_cd <= 0) begin
                lcd_ack  = 1'b1;
                ack_wait = 1'b0;
                ack_hold = 2;
            end
        end else if (lcd_req === 1'b1 && !lcd_ack) begin
            if (ack_lat <= 1) begin
                lcd_ack  = 1'b1;
                ack_hold = 2;
            end else begin
                ack_cd   = ack_lat - 1;
                ack_wait = 1'b1;
            end
        end
    endtask

    task automatic resp_clear();
        ula_done = 1'b0;
        lcd_ack  = 1'b0;
        done_cd  = 0;
        ack_wait = 1'b0;
        ack_hold = 0;
    endtask

    task automatic power_up();
        botao_4 = 1'b1;
        for (int k = 0; k < 40 && power_on !== 1'b1; k++) step();
        botao_4 = 1'b0;
        repeat (8) step();
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            step();
            if (busy === 1'b0 && lcd_ack === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        botao_1 = 1'b0; botao_2 = 1'b0; botao_3 = 1'b0; botao_4 = 1'b0;
        resp_clear();
        repeat (3) step();
        checks++; if (ula_op !== 2'b00) begin failures++; $display("FAIL reset_ula_op actual=%b required=00", ula_op); end
        checks++; if (ula_start !== 1'b0) begin failures++; $display("FAIL reset_ula_start actual=%b required=0", ula_start); end
        checks++; if (lcd_req !== 1'b0) begin failures++; $display("FAIL reset_lcd_req actual=%b required=0", lcd_req); end
        checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL reset_power_on actual=%b required=0", power_on); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        rst_n = 1'b1;
        repeat (4) step();
        checks++; if ({power_on, busy} !== 2'b00) begin failures++; $display("FAIL reset_release actual=%b required=00", {power_on, busy}); end
    endtask

    task automatic test_off_state();
        int n0;
        n0 = n_start;
        botao_2 = 1'b1;
        repeat (8) step();
        botao_2 = 1'b0;
        repeat (8) step();
        checks++; if (n_start - n0 != 0) begin failures++; $display("FAIL off_no_start actual=%0d required=0", n_start - n0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL off_busy actual=%b required=0", busy); end
    endtask

    task automatic test_power();
        int t_on, t_off, toggles;
        logic prev;
        t_on = 0; t_off = 0; toggles = 0; prev = power_on;
        botao_4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (power_on !== prev) toggles++;
            if (power_on === 1'b1 && t_on == 0) t_on = k;
            prev = power_on;
        end
        checks++; if (t_on != 2 + DB + PON) begin failures++; $display("FAIL power_on_latency actual=%0d required=%0d", t_on, 2 + DB + PON); end
        checks++; if (toggles != 1) begin failures++; $display("FAIL power_single_toggle actual=%0d required=1", toggles); end
        botao_4 = 1'b0;
        repeat (8) step();
        botao_4 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (power_on === 1'b0 && t_off == 0) t_off = k;
        end
        checks++; if (t_off != 2 + DB + POFF) begin failures++; $display("FAIL power_off_latency actual=%0d required=%0d", t_off, 2 + DB + POFF); end
        checks++; if (power_on !== 1'b0) begin failures++; $display("FAIL power_off_level actual=%b required=0", power_on); end
        botao_4 = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_operation();
        bit got;
        power_up();
        checks++; if (power_on !== 1'b1) begin failures++; $display("FAIL op_power_up actual=%b required=1", power_on); end
        ula_lat = 5; ack_lat = 2; max_run = 0;
        botao_1 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (ula_start === 1'b1) got = 1'b1;
        end
        botao_1 = 1'b0;
        checks++; if (!got) begin failures++; $display("FAIL op_start_seen actual=0 required=1"); end
        checks++; if (ula_op !== 2'b01) begin failures++; $display("FAIL op_code actual=%b required=01", ula_op); end
        step();
        checks++; if ({ula_start, busy} !== 2'b01) begin failures++; $display("FAIL op_start_pulse actual=%b required=01", {ula_start, busy}); end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (lcd_req === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL op_lcd_req_seen actual=0 required=1"); end
        step();
        checks++; if (lcd_req !== 1'b1) begin failures++; $display("FAIL op_req_hold actual=%b required=1", lcd_req); end
        step();
        checks++; if (lcd_req !== 1'b0) begin failures++; $display("FAIL op_req_drop_after_ack actual=%b required=0", lcd_req); end
        step();
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL op_busy_while_ack actual=%b required=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL op_busy_after_ack_low actual=%b required=0", busy); end
        checks++; if (ula_op !== 2'b01) begin failures++; $display("FAIL op_code_held actual=%b required=01", ula_op); end
        checks++; if (max_run != 1) begin failures++; $display("FAIL op_start_width actual=%0d required=1", max_run); end
        repeat (6) step();
    endtask

    task automatic test_bounce();
        int n0;
        bit ok;
        n0 = n_start; max_run = 0; op_at_start = 2'b00;
        ula_lat = 3; ack_lat = 2;
        for (int k = 0; k < 10; k++) begin
            botao_2 = ((k % 2) == 0);
            step();
        end
        botao_2 = 1'b1;
        repeat (8) step();
        botao_2 = 1'b0;
        wait_idle(40, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bounce_idle_timeout actual=busy required=idle"); end
        checks++; if (n_start - n0 != 1) begin failures++; $display("FAIL bounce_start_count actual=%0d required=1", n_start - n0); end
        checks++; if (op_at_start !== 2'b10) begin failures++; $display("FAIL bounce_op actual=%b required=10", op_at_start); end
        repeat (6) step();
    endtask

    task automatic test_priority();
        int n0;
        bit ok;
        n0 = n_start; op_at_start = 2'b00;
        ula_lat = 20; ack_lat = 2;
        botao_1 = 1'b1; botao_3 = 1'b1;
        repeat (6) step();
        botao_1 = 1'b0; botao_3 = 1'b0;
        botao_2 = 1'b1;
        repeat (6) step();
        botao_2 = 1'b0;
        wait_idle(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL prio_idle_timeout actual=busy required=idle"); end
        checks++; if (op_at_start !== 2'b01) begin failures++; $display("FAIL prio_op actual=%b required=01", op_at_start); end
        checks++; if (n_start - n0 != 1) begin failures++; $display("FAIL prio_ignore_busy actual=%0d required=1", n_start - n0); end
        repeat (6) step();
    endtask

    task automatic test_random();
        int n0, mask;
        bit ok;
        logic [1:0] exp_op;
        for (int it = 0; it < 8; it++) begin
            mask    = int'($urandom_range(7, 1));
            ula_lat = int'($urandom_range(8, 2));
            ack_lat = int'($urandom_range(4, 1));
            exp_op  = model_op(mask);
            n0 = n_start; max_run = 0; op_at_start = 2'b00;
            botao_1 = ((mask & 1) != 0);
            botao_2 = ((mask & 2) != 0);
            botao_3 = ((mask & 4) != 0);
            repeat (int'($urandom_range(9, 6))) step();
            botao_1 = 1'b0; botao_2 = 1'b0; botao_3 = 1'b0;
            wait_idle(60, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rand_idle_timeout it=%0d actual=busy required=idle", it); end
            checks++; if (n_start - n0 != 1 || max_run != 1) begin failures++; $display("FAIL rand_start it=%0d actual=count%0d/width%0d required=1/1", it, n_start - n0, max_run); end
            checks++; if (op_at_start !== exp_op || ula_op !== exp_op) begin failures++; $display("FAIL rand_op it=%0d mask=%0d actual=%b/%b required=%b", it, mask, op_at_start, ula_op, exp_op); end
            repeat (6) step();
        end
    endtask

    task automatic test_poweroff_mid();
        bit got;
        ula_lat = 3; ack_lat = 1000;
        botao_3 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if (k == 7) botao_3 = 1'b0;
            if (lcd_req === 1'b1) got = 1'b1;
        end
        botao_3 = 1'b0;
        checks++; if (!got) begin failures++; $display("FAIL poff_lcd_req_seen actual=0 required=1"); end
        botao_4 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (power_on === 1'b0) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL poff_power_drop actual=1 required=0"); end
        step();
        checks++; if ({lcd_req, ula_op, busy} !== 4'b0000) begin failures++; $display("FAIL poff_outputs actual=req%b_op%b_busy%b required=req0_op00_busy0", lcd_req, ula_op, busy); end
        botao_4 = 1'b0;
        resp_clear();
        repeat (8) step();
    endtask

    task automatic test_reset_mid();
        bit got;
        power_up();
        ula_lat = 1000; ack_lat = 2;
        botao_1 = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (ula_start === 1'b1) got = 1'b1;
        end
        botao_1 = 1'b0;
        step();
        step();
        checks++; if ({got, busy, power_on, ula_op} !== 5'b11101) begin failures++; $display("FAIL rstmid_pre actual=%b required=11101", {got, busy, power_on, ula_op}); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({ula_op, ula_start, lcd_req, power_on, busy} !== 6'b000000) begin failures++; $display("FAIL rstmid_async actual=%b required=000000", {ula_op, ula_start, lcd_req, power_on, busy}); end
        resp_clear();
        step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_off_state();
        test_power();
        test_operation();
        test_bounce();
        test_priority();
        test_random();
        test_poweroff_mid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencer for the calculator datapath: the button front-end, the ALU (ULA) and the LCD writer.
- Debounces the four front-panel buttons (mult, soma, subt, on/off) and owns the power state.
- Issues one ULA operation per accepted button press, then requests an LCD refresh over a req/ack handshake.
- Sits between the raw board inputs and the seletor/ULA_LCD datapath.

Parameters:
- DB_CYC, 1000: cycles a synchronized button must stay stable before its debounced level changes.
- PWR_ON_CYC, 50000: cycles on/off must be held while OFF to power on.
- PWR_OFF_CYC, 25000: cycles on/off must be held while ON to power off.
- CNT_W, 16: width of the debounce and hold counters; must hold max(DB_CYC, PWR_ON_CYC, PWR_OFF_CYC).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- botao_1  in  1  raw mult button, active high, asynchronous
- botao_2  in  1  raw soma button, active high, asynchronous
- botao_3  in  1  raw subt button, active high, asynchronous
- botao_4  in  1  raw on/off button, active high, asynchronous
- ula_op  out  2  latched operation: 00 none, 01 mult, 10 soma, 11 subt
- ula_start  out  1  one-cycle start pulse to the ULA
- ula_done  in  1  ULA result valid; a single-cycle pulse is sufficient
- lcd_req  out  1  LCD refresh request, level
- lcd_ack  in  1  LCD refresh acknowledge, level
- power_on  out  1  calculator powered
- busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; sequencer in IDLE; power state OFF; all counters 0; synchronizers and debounced levels 0.
- Input path: each button passes through a 2-FF synchronizer, then a debouncer. The debounced level takes a new value after DB_CYC consecutive synchronized samples at that value. Press-to-debounced-edge latency = 2 + DB_CYC cycles.
- Power FSM (states OFF, ON, plus an armed flag):
  - The hold counter increments each cycle debounced on/off is high and armed = 1.
  - OFF: when the counter reaches PWR_ON_CYC, go to ON, clear the counter, armed = 0.
  - ON: when the counter reaches PWR_OFF_CYC, go to OFF, clear the counter, armed = 0.
  - Releasing the button clears the counter and sets armed = 1. A continuous hold therefore toggles exactly once.
  - power_on = (state == ON).
- Sequencer FSM (IDLE, START, WAIT_ULA, LCD_REQ, LCD_WAIT):
  - IDLE: only when power_on = 1, a debounced rising edge on an op button latches ula_op, then go to START.
  - Simultaneous edges: priority mult > soma > subt; the losers are dropped.
  - START: ula_start = 1 for exactly this one cycle, then WAIT_ULA.
  - WAIT_ULA: stay until ula_done = 1, then LCD_REQ.
  - LCD_REQ: lcd_req = 1; hold until lcd_ack = 1, then drop lcd_req and go to LCD_WAIT.
  - LCD_WAIT: wait for lcd_ack = 0, then IDLE (4-phase handshake).
  - ula_op holds its value until the next accepted press. It is cleared to 00 on power-off.
  - Op-button edges in any state other than IDLE are ignored, not queued.
  - ula_done seen in any state other than WAIT_ULA is ignored.
- Power-off mid-operation: the sequencer returns to IDLE on the next cycle. lcd_req and ula_start drop immediately; ula_op becomes 00.
- Counter wrap: counters saturate at their threshold and never wrap.

Optional Feature:
- Macro: CALC_ULA_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 1024) and output ula_err (1 bit).
  - If WAIT_ULA lasts TIMEOUT_CYC cycles without ula_done, the sequencer goes to IDLE and sets ula_err = 1.
  - ula_err is sticky until the next accepted press or power-off.
- Undefined: no timeout; WAIT_ULA waits indefinitely; the ula_err port is absent.

Decomposition:
- Package calc_pkg holds:
  - the op encoding constants OP_NONE, OP_MULT, OP_SOMA, OP_SUBT;
  - the sequencer state encoding;
  - the power state encoding.
- Sub-module btn_debounce (synchronizer + debounce counter, parameter DB_CYC) is instantiated four times.

Test Plan (bench parameters: DB_CYC=3, PWR_ON_CYC=8, PWR_OFF_CYC=4):
- Power-on: hold botao_4 high for 20 cycles -> power_on rises 2+3+8 = 13 cycles after the press, with exactly one toggle. Release, then hold again for 10 cycles -> power_on falls.
- Bounce: toggle botao_2 every cycle for 10 cycles, then hold it high -> exactly one ula_start, with ula_op=10.
- Operation: power on, press botao_1; bench returns ula_done 5 cycles after ula_start and lcd_ack 2 cycles after lcd_req -> ula_start is a one-cycle pulse, ula_op=01, lcd_req falls the cycle after ack, busy returns to 0 after ack falls.
- Priority and ignore: press botao_1 and botao_3 in the same cycle -> ula_op=01. Press botao_2 during WAIT_ULA -> no second start.
- Off-state: press botao_2 while power_on=0 -> no ula_start. Power off during LCD_REQ -> lcd_req=0 the next cycle, ula_op=00, busy=0.
- Reset: assert rst_n low during WAIT_ULA -> all outputs 0 immediately, with no clock edge.
